// File: rtl/minmax_scan_ctrl.sv
// Burst min/max scanner: consumes a valid/ready sample stream, tracks the extrema
// (earliest index wins on ties), the all-equal flag and the beat count, then pulses done.
module minmax_scan_ctrl #(
  parameter  int W         = 5,
  parameter  int MAX_BEATS = 16,
  localparam int IW        = $clog2(MAX_BEATS),
  localparam int CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  max_val,
  output logic [IW-1:0] max_idx,
  output logic [W-1:0]  min_val,
  output logic [IW-1:0] min_idx,
  output logic [CW-1:0] count,
  output logic          eq_all,
  output logic          ovf
);

  typedef enum logic [1:0] {IDLE, FIRST, SCAN, DONE} state_t;

  localparam logic [CW-1:0] LAST_K = CW'(MAX_BEATS - 1);

  state_t state;
  logic   beat;
  logic   gt_max, lt_min, eq_max, eq_min;

  assign beat = in_valid & in_ready;

  // Two unsigned magnitude compares per beat, both against the pre-update extrema.
  assign gt_max = in_data > max_val;
  assign eq_max = in_data == max_val;
  assign lt_min = in_data < min_val;
  assign eq_min = in_data == min_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      max_val  <= '0;
      max_idx  <= '0;
      min_val  <= '0;
      min_idx  <= '0;
      count    <= '0;
      eq_all   <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FIRST;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            max_val  <= '0;
            max_idx  <= '0;
            min_val  <= '0;
            min_idx  <= '0;
            count    <= '0;
            eq_all   <= 1'b1;
            ovf      <= 1'b0;
          end
        end
        FIRST: begin
          if (beat) begin
            max_val <= in_data;
            min_val <= in_data;
            max_idx <= '0;
            min_idx <= '0;
            count   <= CW'(1);
            if (in_last || MAX_BEATS == 1) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              ovf      <= ~in_last;
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (beat) begin
            if (gt_max) begin
              max_val <= in_data;
              max_idx <= count[IW-1:0];
            end
            if (lt_min) begin
              min_val <= in_data;
              min_idx <= count[IW-1:0];
            end
            if (!eq_max || !eq_min) eq_all <= 1'b0;
            count <= count + CW'(1);
            // Close the burst on in_last or when the last index slot has been used.
            if (in_last || count == LAST_K) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              ovf      <= ~in_last;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_scan_ctrl.sv
// Bench for minmax_scan_ctrl: table of directed bursts, hand-written reset/start
// sequences, and random bursts checked against a plain array-based reference model.
module tb_minmax_scan_ctrl;

  localparam int W = 5;
  localparam int MB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, in_valid, in_last;
  logic [4:0] in_data;
  logic       in_ready, busy, done, eq_all, ovf;
  logic [4:0] max_val, min_val;
  logic [3:0] max_idx, min_idx;
  logic [4:0] count;

  int tests = 0;
  int fails = 0;

  minmax_scan_ctrl #(.W(W), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .busy(busy), .done(done),
    .max_val(max_val), .max_idx(max_idx), .min_val(min_val), .min_idx(min_idx),
    .count(count), .eq_all(eq_all), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0][4:0] d;
    int n;
    bit last;
    bit gaps;
    bit smid;
    int emax, emaxi, emin, emini, ecnt, eeq, eovf;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_max"}, int'(max_val) + int'(max_idx), 0);
    check({tag, "_min"}, int'(min_val) + int'(min_idx), 0);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_flags"}, int'(eq_all) + int'(ovf), 0);
  endtask

  function automatic logic [15:0][4:0] pack16(input int v[16]);
    logic [15:0][4:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[i][4:0];
    return r;
  endfunction

  // Reference: extrema with first occurrence, equality over all samples.
  task automatic ref_model(input logic [15:0][4:0] d, input int n,
                           output int mx, output int mxi, output int mn, output int mni,
                           output int eq);
    mx = -1; mn = 99; mxi = 0; mni = 0; eq = 1;
    for (int i = 0; i < n; i++) begin
      if (int'(d[i]) > mx) begin mx = int'(d[i]); mxi = i; end
      if (int'(d[i]) < mn) begin mn = int'(d[i]); mni = i; end
      if (d[i] != d[0]) eq = 0;
    end
  endtask

  task automatic run_burst(input string tag, input vec_t v);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_ready_first"}, int'(in_ready), 1);
    check({tag, "_busy"}, int'(busy), 1);
    for (int i = 0; i < v.n; i++) begin
      if (v.gaps && (i % 2 == 1)) begin
        in_valid = 1'b0;
        if (v.smid) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_ready_gap"}, int'(in_ready), 1);
      end
      if (!in_ready) begin
        check({tag, "_ready_beat"}, int'(in_ready), 1);
        in_valid = 1'b0;
        return;
      end
      in_valid = 1'b1;
      in_data  = v.d[i];
      in_last  = v.last && (i == v.n - 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 5'($urandom);
      if (i < v.n - 1 && done) check({tag, "_early_done"}, int'(done), 0);
    end
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_max_val"}, int'(max_val), v.emax);
    check({tag, "_max_idx"}, int'(max_idx), v.emaxi);
    check({tag, "_min_val"}, int'(min_val), v.emin);
    check({tag, "_min_idx"}, int'(min_idx), v.emini);
    check({tag, "_count"}, int'(count), v.ecnt);
    check({tag, "_eq_all"}, int'(eq_all), v.eeq);
    check({tag, "_ovf"}, int'(ovf), v.eovf);
    check({tag, "_ready_done"}, int'(in_ready), 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_hold_max"}, int'(max_val), v.emax);
    @(negedge clk);
    check({tag, "_no_queued_start"}, int'(in_ready) + int'(busy), 0);
    $display("[TB] burst %s n=%0d max=%0d/%0d min=%0d/%0d count=%0d eq=%0d ovf=%0d",
             tag, v.n, max_val, max_idx, min_val, min_idx, count, eq_all, ovf);
  endtask

  initial begin
    vec_t r;
    int mx, mxi, mn, mni, eq;

    tbl[0] = '{d: pack16('{12,6,14,30,6,0,0,0,0,0,0,0,0,0,0,0}), n: 5, last: 1, gaps: 0, smid: 0,
               emax: 30, emaxi: 3, emin: 6, emini: 1, ecnt: 5, eeq: 0, eovf: 0};
    tbl[1] = '{d: pack16('{30,30,30,0,0,0,0,0,0,0,0,0,0,0,0,0}), n: 3, last: 1, gaps: 0, smid: 0,
               emax: 30, emaxi: 0, emin: 30, emini: 0, ecnt: 3, eeq: 1, eovf: 0};
    tbl[2] = '{d: pack16('{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}), n: 1, last: 1, gaps: 0, smid: 0,
               emax: 0, emaxi: 0, emin: 0, emini: 0, ecnt: 1, eeq: 1, eovf: 0};
    tbl[3] = '{d: pack16('{1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,16}), n: 16, last: 0, gaps: 0,
               smid: 0, emax: 16, emaxi: 15, emin: 1, emini: 0, ecnt: 16, eeq: 0, eovf: 1};
    tbl[4] = '{d: pack16('{6,12,12,6,0,0,0,0,0,0,0,0,0,0,0,0}), n: 4, last: 1, gaps: 1, smid: 1,
               emax: 12, emaxi: 1, emin: 6, emini: 0, ecnt: 4, eeq: 0, eovf: 0};
    tbl[5] = '{d: pack16('{31,20,20,0,0,0,0,0,0,0,0,0,0,0,0,0}), n: 5, last: 1, gaps: 1, smid: 0,
               emax: 31, emaxi: 0, emin: 0, emini: 3, ecnt: 5, eeq: 0, eovf: 0};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    #2;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", int'(in_ready), 0);

    for (int t = 0; t < 6; t++) run_burst($sformatf("tbl%0d", t), tbl[t]);

    // Reset in the middle of a burst, then a clean burst from index 0.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = tbl[0].d[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("midscan_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    $display("[TB] reset asserted mid-SCAN after 3 beats");
    @(negedge clk); rst_n = 1'b1;
    run_burst("post_rst", tbl[0]);

    for (int k = 0; k < 24; k++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      r.last = ($urandom_range(0, 3) != 0);
      r.n    = r.last ? int'($urandom_range(1, 16)) : 16;
      r.gaps = ($urandom_range(0, 1) == 1);
      r.smid = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < 16; i++) r.d[i] = 5'($urandom_range(0, narrow ? 2 : 31));
      ref_model(r.d, r.n, mx, mxi, mn, mni, eq);
      r.emax = mx; r.emaxi = mxi; r.emin = mn; r.emini = mni; r.eeq = eq;
      r.ecnt = r.n; r.eovf = r.last ? 0 : 1;
      run_burst($sformatf("rnd%0d", k), r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
